// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Captures data SRAM read data,
// forms load results and forwards the final write value to write-back.
//
// Ports:
//   clk, resetn           : clock, async active-low reset
//   ws_allowin            : write-back can accept
//   ms_allowin            : this stage can accept
//   es_to_ms_valid/_bus   : instruction from execute (117 bits)
//   data_sram_rdata       : SRAM read data, one cycle after address
//   ms_to_ws_valid/_bus   : instruction to write-back (70 bits)
//   ms_waddr, ms_wen      : destination / write-enable for hazards
//   ms_is_valid           : stage holds a valid instruction
//   ms_forward_data       : final result for forwarding
//   ms_is_load            : held instruction reads memory
module mem_stage (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ws_allowin,
    output logic         ms_allowin,
    input  logic         es_to_ms_valid,
    input  logic [116:0] es_to_ms_bus,
    input  logic [31:0]  data_sram_rdata,
    output logic         ms_to_ws_valid,
    output logic [69:0]  ms_to_ws_bus,
    output logic [4:0]   ms_waddr,
    output logic         ms_wen,
    output logic         ms_is_valid,
    output logic [31:0]  ms_forward_data,
    output logic         ms_is_load
);

    localparam int ES_TO_MS_BUS_WD = 117;
    localparam int MS_TO_WS_BUS_WD = 70;

    // load select bits within load_store_op
    localparam int OP_LW  = 11;
    localparam int OP_LB  = 10;
    localparam int OP_LBU = 9;
    localparam int OP_LH  = 8;
    localparam int OP_LHU = 7;
    localparam int OP_LWL = 6;
    localparam int OP_LWR = 5;

    // ------------------------------------------------------------
    // State
    // ------------------------------------------------------------
    logic                       ms_valid_q;
    logic                       first_cycle_q;
    logic [31:0]                rdata_hold_q;
    logic [ES_TO_MS_BUS_WD-1:0] bus_q;

    logic ms_valid_d;
    logic first_cycle_d;
    logic [31:0] rdata_hold_d;
    logic [ES_TO_MS_BUS_WD-1:0] bus_d;

    logic ms_ready_go;
    logic accept;

    // ------------------------------------------------------------
    // Bus field decode
    // ------------------------------------------------------------
    logic [31:0] rt_value;
    logic [11:0] ls_op;
    logic [1:0]  vaddr;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    assign rt_value     = bus_q[116:85];
    assign ls_op        = bus_q[84:73];
    assign vaddr        = bus_q[72:71];
    assign res_from_mem = bus_q[70];
    assign gr_we        = bus_q[69];
    assign dest         = bus_q[68:64];
    assign alu_result   = bus_q[63:32];
    assign pc           = bus_q[31:0];

    // ------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    // ------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------
    always_comb begin
        ms_valid_d    = ms_valid_q;
        bus_d         = bus_q;
        rdata_hold_d  = rdata_hold_q;
        first_cycle_d = 1'b0;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (accept) begin
            bus_d         = es_to_ms_bus;
            first_cycle_d = 1'b1;
        end
        // SRAM address follows execute, so rdata is only good in the
        // first resident cycle; keep a copy for stalled cycles.
        if (first_cycle_q) begin
            rdata_hold_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid_q    <= 1'b0;
            first_cycle_q <= 1'b0;
            rdata_hold_q  <= 32'h0;
            bus_q         <= '0;
        end else begin
            ms_valid_q    <= ms_valid_d;
            first_cycle_q <= first_cycle_d;
            rdata_hold_q  <= rdata_hold_d;
            bus_q         <= bus_d;
        end
    end

    // ------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------
    logic [31:0] mem_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] lwl_val;
    logic [31:0] lwr_val;
    logic [31:0] load_val;
    logic [31:0] final_result;

    assign mem_word = first_cycle_q ? data_sram_rdata : rdata_hold_q;

    always_comb begin
        ld_byte = mem_word[7:0];
        case (vaddr)
            2'd0: ld_byte = mem_word[7:0];
            2'd1: ld_byte = mem_word[15:8];
            2'd2: ld_byte = mem_word[23:16];
            2'd3: ld_byte = mem_word[31:24];
            default: ld_byte = mem_word[7:0];
        endcase
    end

    // halfword select ignores vaddr[0]
    assign ld_half = vaddr[1] ? mem_word[31:16] : mem_word[15:0];

    always_comb begin
        lwl_val = mem_word;
        case (vaddr)
            2'd0: lwl_val = {mem_word[7:0],  rt_value[23:0]};
            2'd1: lwl_val = {mem_word[15:0], rt_value[15:0]};
            2'd2: lwl_val = {mem_word[23:0], rt_value[7:0]};
            2'd3: lwl_val = mem_word;
            default: lwl_val = mem_word;
        endcase
    end

    always_comb begin
        lwr_val = mem_word;
        case (vaddr)
            2'd0: lwr_val = mem_word;
            2'd1: lwr_val = {rt_value[31:24], mem_word[31:8]};
            2'd2: lwr_val = {rt_value[31:16], mem_word[31:16]};
            2'd3: lwr_val = {rt_value[31:8],  mem_word[31:24]};
            default: lwr_val = mem_word;
        endcase
    end

    // load select is one-hot or all zero
    always_comb begin
        load_val = mem_word;
        unique case (1'b1)
            ls_op[OP_LW]:  load_val = mem_word;
            ls_op[OP_LB]:  load_val = {{24{ld_byte[7]}}, ld_byte};
            ls_op[OP_LBU]: load_val = {24'h0, ld_byte};
            ls_op[OP_LH]:  load_val = {{16{ld_half[15]}}, ld_half};
            ls_op[OP_LHU]: load_val = {16'h0, ld_half};
            ls_op[OP_LWL]: load_val = lwl_val;
            ls_op[OP_LWR]: load_val = lwr_val;
            default:       load_val = mem_word;
        endcase
    end

    assign final_result = res_from_mem ? load_val : alu_result;

    // ------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------
    logic [MS_TO_WS_BUS_WD-1:0] ws_bus;

    assign ws_bus          = {gr_we, dest, final_result, pc};
    assign ms_to_ws_bus    = ws_bus;
    assign ms_waddr        = dest;
    assign ms_wen          = gr_we;
    assign ms_is_valid     = ms_valid_q;
    assign ms_forward_data = final_result;
    assign ms_is_load      = res_from_mem;

endmodule
